// File: rtl/nn_fixed_pkg.sv
// Shared fixed-point definitions (scale 1e7) for the neuron datapath:
// value type, sigmoid breakpoints/offsets, saturation limits and FSM states.
package nn_fixed_pkg;

  typedef logic signed [31:0] fx_t;

  localparam fx_t SCALE = 32'sd10_000_000;
  localparam fx_t ONE   = 32'sd10_000_000;
  localparam fx_t HALF  = 32'sd5_000_000;

  // Piecewise-linear sigmoid: breakpoints on |net| and the offsets of each segment
  localparam fx_t SIG_SAT_BP  = 32'sd50_000_000;
  localparam fx_t SIG_HI_BP   = 32'sd23_750_000;
  localparam fx_t SIG_MID_BP  = 32'sd10_000_000;
  localparam fx_t SIG_HI_OFF  = 32'sd8_437_500;
  localparam fx_t SIG_MID_OFF = 32'sd6_250_000;
  localparam fx_t SIG_LO_OFF  = HALF;

  localparam logic signed [63:0] FX_MAX = 64'sd2147483647;
  localparam logic signed [63:0] FX_MIN = -64'sd2147483648;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_ACT,
    ST_HOLD
  } nf_state_t;

  function automatic fx_t sat_fx(input logic signed [63:0] v);
    fx_t r;
    if (v > FX_MAX) r = 32'sh7fff_ffff;
    else if (v < FX_MIN) r = 32'sh8000_0000;
    else r = v[31:0];
    return r;
  endfunction

endpackage

// File: rtl/sigmoid_pwl.sv
// Combinational piecewise-linear sigmoid: maps a saturated net value to an
// activation in 0..ONE. Shared with the weight-update path.
module sigmoid_pwl
  import nn_fixed_pkg::*;
(
  input  fx_t net,
  output fx_t out
);

  logic [32:0] mag;
  logic [32:0] y;

  always_comb begin
    // 33 bits so that |-2^31| is representable
    mag = net[31] ? (33'd0 - {1'b1, net}) : {1'b0, net};
    if (mag >= 33'(SIG_SAT_BP))      y = 33'(ONE);
    else if (mag >= 33'(SIG_HI_BP))  y = (mag >> 5) + 33'(SIG_HI_OFF);
    else if (mag >= 33'(SIG_MID_BP)) y = (mag >> 3) + 33'(SIG_MID_OFF);
    else                             y = (mag >> 2) + 33'(SIG_LO_OFF);
    out = net[31] ? (ONE - signed'(y[31:0])) : signed'(y[31:0]);
  end

endmodule

// File: rtl/neuron_forward.sv
// Forward-pass neuron: bias plus serially streamed input*weight products,
// saturated and passed through the PWL sigmoid, with valid/ready handshakes.
module neuron_forward
  import nn_fixed_pkg::*;
#(
  parameter int               N_INPUTS = 4,
  parameter logic signed [31:0] BIAS   = 32'sd0,
  parameter logic signed [31:0] W_INIT = 32'sd5_000_000,
  localparam int              AW       = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          w_we,
  input  logic [AW-1:0] w_addr,
  input  logic [31:0]   w_data,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out,
  output logic [31:0]   net,
  output logic          busy
);

  nf_state_t state_reg, state_next;
  logic [AW-1:0] idx_reg;
  logic signed [63:0] acc_reg;
  logic signed [63:0] prod_full;
  logic signed [63:0] prod_scaled;
  fx_t w_vec [N_INPUTS];
  fx_t w_sel;
  fx_t net_sat, out_pwl;
  fx_t net_reg, out_reg;
  logic take, w_write, last_in;

  assign take    = (state_reg == ST_ACCUM) && in_valid;
  assign w_write = (state_reg == ST_IDLE) && w_we;
  assign last_in = (idx_reg == AW'(N_INPUTS - 1));

  // Weight register file; writes outside IDLE are dropped
  genvar gi;
  generate
    for (gi = 0; gi < N_INPUTS; gi++) begin : g_w
      fx_t w_reg;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) w_reg <= W_INIT;
        else if (w_write && (w_addr == AW'(gi))) w_reg <= signed'(w_data);
      end
      assign w_vec[gi] = w_reg;
    end
  endgenerate

  assign w_sel       = w_vec[idx_reg];
  assign prod_full   = 64'(signed'(in_data)) * 64'(w_sel);
  // Signed division truncates toward zero, so -0.9 raw units contributes 0
  assign prod_scaled = prod_full / 64'(SCALE);
  assign net_sat     = sat_fx(acc_reg);

  sigmoid_pwl u_sigmoid (
    .net (net_sat),
    .out (out_pwl)
  );

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_IDLE:  if (start) state_next = ST_ACCUM;
      ST_ACCUM: if (take && last_in) state_next = ST_ACT;
      ST_ACT:   state_next = ST_HOLD;
      ST_HOLD:  if (out_ready) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      acc_reg   <= '0;
      idx_reg   <= '0;
      net_reg   <= '0;
      out_reg   <= '0;
    end else begin
      state_reg <= state_next;
      unique case (state_reg)
        ST_IDLE: begin
          if (start) begin
            acc_reg <= 64'(BIAS);
            idx_reg <= '0;
          end
        end
        ST_ACCUM: begin
          if (take) begin
            acc_reg <= acc_reg + prod_scaled;
            idx_reg <= idx_reg + AW'(1);
          end
        end
        ST_ACT: begin
          net_reg <= net_sat;
          out_reg <= out_pwl;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_reg == ST_ACCUM);
  assign out_valid = (state_reg == ST_HOLD);
  assign busy      = (state_reg != ST_IDLE);
  assign net       = net_reg;
  assign out       = out_reg;

endmodule

// File: tb/tb_neuron_forward.sv
// Self-checking bench for neuron_forward: directed vector table, randomized
// evaluations against an arithmetic reference model, and protocol corner cases.
module tb_neuron_forward;
  import nn_fixed_pkg::*;

  localparam int N     = 4;
  localparam int LIMIT = 100;
  localparam fx_t WI   = 32'sd5_000_000;

  typedef fx_t vec_t [N];
  typedef struct {
    fx_t    w;
    fx_t    x;
    longint e_net;
    longint e_out;
  } vec_case_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       w_we = 1'b0;
  logic [1:0] w_addr = '0;
  logic [31:0] w_data = '0;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [31:0] in_data = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [31:0] out_s;
  logic [31:0] net_s;
  logic       busy;

  int  vectors = 0;
  int  miscompares = 0;
  fx_t mw [N];

  neuron_forward #(.N_INPUTS(N), .BIAS(32'sd0), .W_INIT(WI)) dut (
    .clk       (clk),
    .reset     (reset),
    .w_we      (w_we),
    .w_addr    (w_addr),
    .w_data    (w_data),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out_s),
    .net       (net_s),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model straight from the arithmetic rules
  function automatic longint model_net(input vec_t w, input vec_t x);
    longint s = 0;
    for (int i = 0; i < N; i++)
      s += (longint'(x[i]) * longint'(w[i])) / 64'sd10_000_000;
    if (s > 64'sd2147483647) s = 64'sd2147483647;
    if (s < -64'sd2147483648) s = -64'sd2147483648;
    return s;
  endfunction

  function automatic longint model_out(input longint n);
    longint a, y;
    a = (n < 0) ? -n : n;
    if (a >= 50_000_000)      y = 10_000_000;
    else if (a >= 23_750_000) y = a / 32 + 8_437_500;
    else if (a >= 10_000_000) y = a / 8 + 6_250_000;
    else                      y = a / 4 + 5_000_000;
    return (n < 0) ? 10_000_000 - y : y;
  endfunction

  function automatic fx_t rnd_fx();
    if ($urandom_range(0, 3) == 0) return fx_t'($urandom);
    return fx_t'(int'($urandom_range(0, 30_000_000)) - 15_000_000);
  endfunction

  // Caller is at a negedge in IDLE
  task automatic set_weights(input vec_t w);
    for (int i = 0; i < N; i++) begin
      w_we = 1'b1; w_addr = 2'(i); w_data = w[i];
      @(negedge clk);
      mw[i] = w[i];
    end
    w_we = 1'b0;
  endtask

  // Starts at the current negedge; returns at the negedge after the handshake
  task automatic run_eval(input vec_t x, input int gaps, input int hold,
                          input int accum_write, output longint g_net,
                          output longint g_out, output int lat);
    int i;
    start = 1'b1; lat = 0;
    @(negedge clk);
    start = 1'b0; w_we = 1'b0; lat = 1; i = 0;
    while (i < N && lat < LIMIT) begin
      if (accum_write != 0) begin w_we = 1'b1; w_addr = 2'd0; w_data = '0; end
      if (gaps != 0 && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0; in_data = $urandom;
      end else begin
        in_valid = 1'b1; in_data = x[i];
        if (in_ready) i++;
      end
      @(negedge clk); lat++;
    end
    in_valid = 1'b0; w_we = 1'b0;
    while (!out_valid && lat < LIMIT) begin
      @(negedge clk); lat++;
    end
    if (lat >= LIMIT) check("timeout", lat, 0);
    g_net = longint'(signed'(net_s));
    g_out = longint'(signed'(out_s));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_out", longint'(signed'(out_s)), g_out);
      check("hold_net", longint'(signed'(net_s)), g_net);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("post_valid", out_valid, 0);
    check("post_busy", busy, 0);
    check("post_out", longint'(signed'(out_s)), g_out);
  endtask

  vec_case_t tbl [8];

  initial begin
    vec_t w, x;
    longint g_net, g_out, e_net;
    int lat;

    tbl[0] = '{32'sd5_000_000,     32'sd10_000_000,     64'sd20_000_000,  64'sd8_750_000};
    tbl[1] = '{32'sd0,             32'sd10_000_000,     64'sd0,           64'sd5_000_000};
    tbl[2] = '{-32'sd5_000_000,    32'sd10_000_000,     -64'sd20_000_000, 64'sd1_250_000};
    tbl[3] = '{32'sd2_000_000_000, 32'sd2_000_000_000,  64'sd2147483647,  64'sd10_000_000};
    tbl[4] = '{32'sd2_000_000_000, -32'sd2_000_000_000, -64'sd2147483648, 64'sd0};
    tbl[5] = '{32'sd3_000_000,     -32'sd3,             64'sd0,           64'sd5_000_000};
    tbl[6] = '{32'sd10_000_000,    32'sd6_000_000,      64'sd24_000_000,  64'sd9_187_500};
    tbl[7] = '{32'sd10_000_000,    -32'sd1_500_000,     -64'sd6_000_000,  64'sd3_500_000};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out", out_s, 0);
    check("rst_net", net_s, 0);
    reset = 1'b0;
    foreach (mw[i]) mw[i] = WI;
    @(negedge clk);

    // Directed table
    for (int k = 0; k < 8; k++) begin
      foreach (w[i]) w[i] = tbl[k].w;
      foreach (x[i]) x[i] = tbl[k].x;
      set_weights(w);
      run_eval(x, 0, 0, 0, g_net, g_out, lat);
      $display("vec %0d: net=%0d out=%0d lat=%0d", k, g_net, g_out, lat);
      check("tbl_net", g_net, tbl[k].e_net);
      check("tbl_out", g_out, tbl[k].e_out);
      check("tbl_latency", lat, N + 2);
    end

    // Randomized evaluations with input gaps and output backpressure
    for (int k = 0; k < 24; k++) begin
      foreach (w[i]) w[i] = rnd_fx();
      foreach (x[i]) x[i] = rnd_fx();
      set_weights(w);
      run_eval(x, 1, int'($urandom_range(0, 3)), 0, g_net, g_out, lat);
      e_net = model_net(mw, x);
      $display("rnd %0d: net=%0d exp=%0d out=%0d", k, g_net, e_net, g_out);
      check("rnd_net", g_net, e_net);
      check("rnd_out", g_out, model_out(e_net));
    end

    // Backpressure: five cycles with out_ready low
    foreach (w[i]) w[i] = 32'sd5_000_000;
    foreach (x[i]) x[i] = 32'sd10_000_000;
    set_weights(w);
    run_eval(x, 0, 5, 0, g_net, g_out, lat);
    $display("backpressure: net=%0d out=%0d", g_net, g_out);
    check("bp_out", g_out, 8_750_000);

    // out_ready while nothing is valid
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("idle_ready_busy", busy, 0);
    check("idle_ready_valid", out_valid, 0);

    // Weight write during ACCUM dropped, then a back-to-back evaluation
    run_eval(x, 0, 0, 1, g_net, g_out, lat);
    $display("accum write: net=%0d", g_net);
    check("drop_net", g_net, 20_000_000);
    run_eval(x, 0, 0, 0, g_net, g_out, lat);
    $display("back-to-back: net=%0d lat=%0d", g_net, lat);
    check("b2b_net", g_net, 20_000_000);
    check("b2b_latency", lat, N + 2);

    // Weight write coincident with start is used
    w_we = 1'b1; w_addr = 2'd1; w_data = -32'sd5_000_000;
    mw[1] = -32'sd5_000_000;
    run_eval(x, 0, 0, 0, g_net, g_out, lat);
    e_net = model_net(mw, x);
    $display("start write: net=%0d exp=%0d", g_net, e_net);
    check("cowrite_net", g_net, e_net);
    check("cowrite_out", g_out, model_out(e_net));

    // Reset mid-ACCUM discards the partial sum and reloads weights
    foreach (w[i]) w[i] = 32'sd0;
    set_weights(w);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; in_data = 32'sd10_000_000;
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    $display("mid reset: in_ready=%0d busy=%0d out=%0d net=%0d", in_ready, busy, out_s, net_s);
    check("mrst_in_ready", in_ready, 0);
    check("mrst_busy", busy, 0);
    check("mrst_out", out_s, 0);
    check("mrst_net", net_s, 0);
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    foreach (mw[i]) mw[i] = WI;
    @(negedge clk);
    run_eval(x, 0, 0, 0, g_net, g_out, lat);
    $display("after reset: net=%0d out=%0d", g_net, g_out);
    check("mrst_winit_net", g_net, 20_000_000);
    check("mrst_winit_out", g_out, 8_750_000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
